qbu_tx_sched: RTL
=================

// Module: qbu_tx_sched
// PURPOSE
//   Frame-level scheduler for the QBU transmit mux. Grants the single MAC transmit path to one source:
//   eMAC (express), pMAC (preemptable), verify or eth (plain). Tracks the link mode from the verify result,
//   inserts the inter-frame gap, and raises a preemption request to the pMAC framer when express traffic waits.
//   Sits beside the tx mux and drives its one-hot select.
// PARAMETERS
//   IFG_CYCLES      12   idle cycles forced between the end of one burst and the next grant (>=1)
//   MIN_FRAG_BYTES  60   pMAC beats (1 byte/beat) that must be sent in a grant before preemption is allowed
// PORTS
//   i_clk              in   1   clock
//   i_rst              in   1   asynchronous reset, active-high
//   i_verify_succ      in   1   verify outcome, 1 = success
//   i_verify_succ_val  in   1   one-cycle strobe qualifying i_verify_succ
//   i_emac_req         in   1   eMAC has a frame pending
//   i_pmac_req         in   1   pMAC has a frame or fragment pending
//   i_verify_req       in   1   verify generator has a frame pending
//   i_eth_req          in   1   plain eth source has a frame pending
//   i_beat             in   1   beat accepted on MAC path (valid & ready)
//   i_last             in   1   beat is last of burst; qualified by i_beat
//   i_pmac_crc         in   1   pMAC end type on last beat: 1 = CRC (frame done), 0 = mCRC (fragment)
//   o_grant            out  4   one-hot {eth, verify, pmac, emac}; 0 = nobody
//   o_preempt_req      out  1   pMAC must close current fragment with mCRC at next legal point
//   o_mode             out  2   00 verifying, 10 QBU, 11 normal
//   o_busy             out  1   state != IDLE
//   o_preempt_cnt      out  16  completed preemptions, saturating
// BEHAVIOUR
//   Reset: o_grant=0, o_preempt_req=0, o_mode=00, o_busy=0, o_preempt_cnt=0, state IDLE, counters 0.
//   Mode reg: succ_val&succ -> 10; succ_val&!succ -> 11; else hold. Updates o_mode next cycle.
//   New mode affects arbitration only. Burst in progress always completes.
//   States: IDLE, G_EMAC, G_PMAC, G_VERIFY, G_ETH, GAP. All outputs are registered.
//   IDLE arbitration by mode (grant visible 1 cycle after req seen in IDLE):
//     00: verify only. 10: emac > pmac. 11: emac > eth. Reqs not listed for the mode are ignored.
//   G_x: o_grant holds its one-hot bit until i_beat&i_last, then next state is GAP and o_grant=0 next cycle.
//   GAP: gap_cnt counts IFG_CYCLES cycles with grant 0, then IDLE. Arbitration occurs in IDLE.
//   Back-to-back frame spacing is IFG_CYCLES+1 idle grant cycles.
//   i_beat while in IDLE/GAP is ignored.
//   G_PMAC byte_cnt (16b): cleared on entry, +1 per i_beat, saturates at MIN_FRAG_BYTES.
//   o_preempt_req set when in G_PMAC & i_emac_req & byte_cnt>=MIN_FRAG_BYTES & !(i_beat&i_last).
//   o_preempt_req stays high until the pMAC last beat, then clears. It never deasserts on emac_req drop.
//   Preemption counts when the last beat has preempt_req=1 & i_pmac_crc=0: o_preempt_cnt+1, sat at FFFF.
//   If i_pmac_crc=1, the frame ended naturally: no count.
//   After a preempted fragment: GAP, then IDLE grants eMAC by priority. pMAC resumes later via i_pmac_req.
//   Simultaneous: succ_val on the same cycle as an IDLE arbitration -> old mode arbitrates that cycle.
//   emac_req and last beat on the same cycle -> no preempt_req assertion.
//   Reset mid-burst: immediate return to reset values; no partial-state retention.
// TESTING
//   Reset, verify_req=1, mode 00 -> o_grant=0100 one cycle later.
//   10 beats then last -> grant 0 for 12 cycles, then IDLE.
//   succ_val&succ=1 -> o_mode=10. emac_req & pmac_req together in IDLE -> o_grant=0001, pmac after eMAC+gap.
//   Mode 10, pmac granted, emac_req at beat 20 -> preempt_req rises after beat 60.
//   pmac last with crc=0 -> preempt_cnt=1, then GAP, then emac grant.
//   Mode 10, emac_req at pmac beat 40, pmac frame ends at beat 50 with crc=1 -> preempt_req never set, cnt 0.
//   succ_val&succ=0 -> mode 11. pmac_req only -> no grant. eth_req -> o_grant=1000.
//   Mode flip during eth burst -> burst completes.
//   Assert i_rst in G_PMAC with preempt_req=1 -> all outputs 0 and o_mode=00 asynchronously.
//   Force 65536 preemptions -> o_preempt_cnt stays FFFF.

Source files
------------

// File: rtl/qbu_tx_sched.sv
// ============================================================================
// Module   : qbu_tx_sched
// Brief    : Frame-level grant scheduler for the QBU transmit mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qbu_tx_sched #(
  parameter int IFG_CYCLES     = 12,
  parameter int MIN_FRAG_BYTES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_verify_succ,
  input  logic        i_verify_succ_val,
  input  logic        i_emac_req,
  input  logic        i_pmac_req,
  input  logic        i_verify_req,
  input  logic        i_eth_req,
  input  logic        i_beat,
  input  logic        i_last,
  input  logic        i_pmac_crc,
  output logic [3:0]  o_grant,
  output logic        o_preempt_req,
  output logic [1:0]  o_mode,
  output logic        o_busy,
  output logic [15:0] o_preempt_cnt
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [1:0]       c_MODE_VERIFY = 2'b00;
  localparam logic [1:0]       c_MODE_QBU    = 2'b10;
  localparam logic [1:0]       c_MODE_NORMAL = 2'b11;
  localparam logic [3:0]       c_GNT_EMAC    = 4'b0001;
  localparam logic [3:0]       c_GNT_PMAC    = 4'b0010;
  localparam logic [3:0]       c_GNT_VERIFY  = 4'b0100;
  localparam logic [3:0]       c_GNT_ETH     = 4'b1000;
  localparam logic [15:0]      c_MIN_FRAG    = 16'(MIN_FRAG_BYTES);
  localparam logic [15:0]      c_CNT_MAX     = 16'hFFFF;
  localparam logic [GAP_W-1:0] c_GAP_LAST    = GAP_W'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_G_EMAC   = 3'd1,
    S_G_PMAC   = 3'd2,
    S_G_VERIFY = 3'd3,
    S_G_ETH    = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t           r_state;
  logic [3:0]       r_grant;
  logic             r_preempt_req;
  logic [1:0]       r_mode;
  logic             r_busy;
  logic [15:0]      r_preempt_cnt;
  logic [15:0]      r_byte_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_end;

  assign w_end = i_beat & i_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 4'b0000;
      r_preempt_req <= 1'b0;
      r_mode        <= c_MODE_VERIFY;
      r_busy        <= 1'b0;
      r_preempt_cnt <= 16'd0;
      r_byte_cnt    <= 16'd0;
      r_gap_cnt     <= '0;
    end else begin
      if (i_verify_succ_val) begin
        r_mode <= i_verify_succ ? c_MODE_QBU : c_MODE_NORMAL;
      end

      // Arbitration below reads r_mode, so a same-cycle strobe uses the old mode.
      case (r_state)
        S_IDLE: begin
          case (r_mode)
            c_MODE_VERIFY: begin
              if (i_verify_req) begin
                r_state <= S_G_VERIFY;
                r_grant <= c_GNT_VERIFY;
                r_busy  <= 1'b1;
              end
            end
            c_MODE_QBU: begin
              if (i_emac_req) begin
                r_state <= S_G_EMAC;
                r_grant <= c_GNT_EMAC;
                r_busy  <= 1'b1;
              end else if (i_pmac_req) begin
                r_state    <= S_G_PMAC;
                r_grant    <= c_GNT_PMAC;
                r_busy     <= 1'b1;
                r_byte_cnt <= 16'd0;
              end
            end
            c_MODE_NORMAL: begin
              if (i_emac_req) begin
                r_state <= S_G_EMAC;
                r_grant <= c_GNT_EMAC;
                r_busy  <= 1'b1;
              end else if (i_eth_req) begin
                r_state <= S_G_ETH;
                r_grant <= c_GNT_ETH;
                r_busy  <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        S_G_EMAC, S_G_VERIFY, S_G_ETH: begin
          if (w_end) begin
            r_state   <= S_GAP;
            r_grant   <= 4'b0000;
            r_gap_cnt <= '0;
          end
        end

        S_G_PMAC: begin
          if (i_beat && (r_byte_cnt < c_MIN_FRAG)) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
          end
          if (w_end) begin
            // Only an mCRC close of a requested preemption counts as one.
            if (r_preempt_req && !i_pmac_crc && (r_preempt_cnt != c_CNT_MAX)) begin
              r_preempt_cnt <= r_preempt_cnt + 16'd1;
            end
            r_preempt_req <= 1'b0;
            r_state       <= S_GAP;
            r_grant       <= 4'b0000;
            r_gap_cnt     <= '0;
          end else if (i_emac_req && (r_byte_cnt >= c_MIN_FRAG)) begin
            r_preempt_req <= 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_preempt_req = r_preempt_req;
  assign o_mode        = r_mode;
  assign o_busy        = r_busy;
  assign o_preempt_cnt = r_preempt_cnt;

endmodule

`default_nettype wire
